// File: rtl/rob_commit_unit_pkg.sv
// Shared constants, state encoding and tag/index helpers for the reorder buffer.
// Tags are 1-based (tag 0 = no dependency); entry index i carries tag i+1.
package rob_commit_unit_pkg;

    localparam int ROB_SIZE = 16;
    localparam int TAG_W    = 5;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = $clog2(ROB_SIZE);
    localparam int CNT_W    = $clog2(ROB_SIZE) + 1;

    localparam logic [TAG_W-1:0] TAG_NONE = 5'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } rob_state_e;

    function automatic logic [TAG_W-1:0] idx_to_tag(input logic [IDX_W-1:0] idx);
        return TAG_W'(idx) + TAG_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
        return IDX_W'(tag - TAG_W'(1));
    endfunction

    function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
        return (tag != TAG_NONE) && (tag <= TAG_W'(ROB_SIZE));
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(ROB_SIZE - 1)) ? IDX_W'(0) : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rob_commit_unit_query_port.sv
// Combinational operand lookup by rename tag, with same-cycle CDB bypass.
module rob_query_port
    import rob_commit_unit_pkg::*;
(
    input  logic [TAG_W-1:0]                query_tag,
    input  logic [ROB_SIZE-1:0]             busy,
    input  logic [ROB_SIZE-1:0]             ready,
    input  logic [ROB_SIZE-1:0][DATA_W-1:0] data,
    input  logic                            cdb_valid,
    input  logic [TAG_W-1:0]                cdb_tag,
    input  logic [DATA_W-1:0]               cdb_data,
    output logic                            query_ready,
    output logic [DATA_W-1:0]               query_data
);

    logic [IDX_W-1:0] idx_s;

    assign idx_s = tag_to_idx(query_tag);

    // Lookup: unknown or free tags report not-ready; a matching broadcast wins over storage.
    always_comb begin
        query_ready = 1'b0;
        query_data  = 32'd0;
        if (tag_in_range(query_tag) && busy[idx_s]) begin
            if (cdb_valid && (cdb_tag == query_tag)) begin
                query_ready = 1'b1;
                query_data  = cdb_data;
            end else begin
                query_ready = ready[idx_s];
                query_data  = data[idx_s];
            end
        end else begin
            query_ready = 1'b0;
            query_data  = 32'd0;
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocation and retirement, CDB result capture,
// and branch-misprediction flush one cycle after the offending commit.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              dispatch_valid,
    input  logic [REG_W-1:0]  dispatch_dest,
    input  logic              dispatch_is_branch,
    input  logic              dispatch_pred_taken,
    input  logic              dispatch_is_store,
    input  logic              dispatch_ready,
    input  logic [DATA_W-1:0] dispatch_data,
    output logic              rob_full,
    output logic [TAG_W-1:0]  rob_next_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_taken,
    input  logic [DATA_W-1:0] cdb_target,
    input  logic [TAG_W-1:0]  query_tag1,
    input  logic [TAG_W-1:0]  query_tag2,
    output logic              query_ready1,
    output logic              query_ready2,
    output logic [DATA_W-1:0] query_data1,
    output logic [DATA_W-1:0] query_data2,
    output logic              rob_valid,
    output logic [REG_W-1:0]  dest,
    output logic [TAG_W-1:0]  dest_depend,
    output logic [DATA_W-1:0] rob_data,
    output logic              wrong_commit,
    output logic [DATA_W-1:0] flush_pc,
    output logic              store_commit,
    output logic [TAG_W-1:0]  store_commit_tag
);

    logic [ROB_SIZE-1:0]             busy_q, busy_d, ready_q, ready_d;
    logic [ROB_SIZE-1:0]             is_branch_q, is_branch_d, pred_q, pred_d;
    logic [ROB_SIZE-1:0]             taken_q, taken_d, is_store_q, is_store_d;
    logic [ROB_SIZE-1:0][REG_W-1:0]  ent_dest_q, ent_dest_d;
    logic [ROB_SIZE-1:0][DATA_W-1:0] ent_data_q, ent_data_d, ent_target_q, ent_target_d;
    logic [IDX_W-1:0]                head_q, head_d, tail_q, tail_d, cdb_idx_s;
    logic [CNT_W-1:0]                count_q, count_d;
    rob_state_e                      state_q, state_d;
    logic [DATA_W-1:0]               redirect_q, redirect_d;
    logic                            rob_valid_q, rob_valid_d, wrong_commit_q, wrong_commit_d;
    logic                            store_commit_q, store_commit_d;
    logic [REG_W-1:0]                dest_q, dest_d;
    logic [TAG_W-1:0]                dest_depend_q, dest_depend_d, store_tag_q, store_tag_d;
    logic [DATA_W-1:0]               rob_data_q, rob_data_d, flush_pc_q, flush_pc_d;
    logic                            full_s, commit_s, accept_s, cdb_hit_s, mispredict_s;

    // Full is judged on registered count, so a same-cycle commit never frees a slot early.
    assign full_s       = (count_q == CNT_W'(ROB_SIZE)) || (state_q == ST_FLUSH);
    assign commit_s     = rdy && (state_q == ST_RUN) && busy_q[head_q] && ready_q[head_q];
    assign accept_s     = rdy && dispatch_valid && !full_s;
    assign cdb_idx_s    = tag_to_idx(cdb_tag);
    assign cdb_hit_s    = rdy && (state_q == ST_RUN) && cdb_valid && tag_in_range(cdb_tag)
                          && busy_q[cdb_idx_s];
    assign mispredict_s = is_branch_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

    // Next-state: flush, or commit / CDB capture / dispatch, all gated by rdy.
    always_comb begin
        busy_d = busy_q;           ready_d = ready_q;
        is_branch_d = is_branch_q; pred_d = pred_q;
        taken_d = taken_q;         is_store_d = is_store_q;
        ent_dest_d = ent_dest_q;   ent_data_d = ent_data_q;
        ent_target_d = ent_target_q;
        head_d = head_q;           tail_d = tail_q;
        count_d = count_q;         state_d = state_q;
        redirect_d = redirect_q;
        rob_valid_d = 1'b0;        wrong_commit_d = 1'b0;
        store_commit_d = 1'b0;     store_tag_d = store_tag_q;
        dest_d = dest_q;           dest_depend_d = dest_depend_q;
        rob_data_d = rob_data_q;   flush_pc_d = flush_pc_q;
        if (rdy && (state_q == ST_FLUSH)) begin
            wrong_commit_d = 1'b1;
            flush_pc_d     = redirect_q;
            busy_d         = '0;
            head_d         = '0;
            tail_d         = '0;
            count_d        = '0;
            state_d        = ST_RUN;
        end else begin
            if (commit_s) begin
                rob_valid_d    = 1'b1;
                dest_d         = ent_dest_q[head_q];
                dest_depend_d  = idx_to_tag(head_q);
                rob_data_d     = ent_data_q[head_q];
                store_commit_d = is_store_q[head_q];
                store_tag_d    = is_store_q[head_q] ? idx_to_tag(head_q) : store_tag_q;
                busy_d[head_q] = 1'b0;
                head_d         = next_idx(head_q);
                state_d        = mispredict_s ? ST_FLUSH : ST_RUN;
                redirect_d     = mispredict_s ? ent_target_q[head_q] : redirect_q;
            end else begin
                rob_valid_d    = 1'b0;
            end
            if (cdb_hit_s) begin
                ready_d[cdb_idx_s]      = 1'b1;
                ent_data_d[cdb_idx_s]   = cdb_data;
                taken_d[cdb_idx_s]      = cdb_taken;
                ent_target_d[cdb_idx_s] = cdb_target;
            end else begin
                ready_d[cdb_idx_s]      = ready_q[cdb_idx_s];
            end
            // A branch known at dispatch defaults its outcome to the prediction.
            if (accept_s) begin
                busy_d[tail_q]       = 1'b1;
                ready_d[tail_q]      = dispatch_ready;
                ent_dest_d[tail_q]   = dispatch_dest;
                ent_data_d[tail_q]   = dispatch_data;
                is_branch_d[tail_q]  = dispatch_is_branch;
                pred_d[tail_q]       = dispatch_pred_taken;
                taken_d[tail_q]      = dispatch_pred_taken;
                is_store_d[tail_q]   = dispatch_is_store;
                ent_target_d[tail_q] = 32'd0;
                tail_d               = next_idx(tail_q);
            end else begin
                tail_d               = tail_q;
            end
            case ({accept_s, commit_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;          head_q <= '0;          tail_q <= '0;
            count_q <= '0;         state_q <= ST_RUN;     redirect_q <= 32'd0;
            rob_valid_q <= 1'b0;   wrong_commit_q <= 1'b0; store_commit_q <= 1'b0;
            store_tag_q <= 5'd0;   dest_q <= 5'd0;        dest_depend_q <= 5'd0;
            rob_data_q <= 32'd0;   flush_pc_q <= 32'd0;
        end else begin
            busy_q <= busy_d;      head_q <= head_d;      tail_q <= tail_d;
            count_q <= count_d;    state_q <= state_d;    redirect_q <= redirect_d;
            rob_valid_q <= rob_valid_d; wrong_commit_q <= wrong_commit_d;
            store_commit_q <= store_commit_d; store_tag_q <= store_tag_d;
            dest_q <= dest_d;      dest_depend_q <= dest_depend_d;
            rob_data_q <= rob_data_d; flush_pc_q <= flush_pc_d;
        end
    end

    // Entry payload; only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        ready_q <= ready_d;         is_branch_q <= is_branch_d;
        pred_q <= pred_d;           taken_q <= taken_d;
        is_store_q <= is_store_d;   ent_dest_q <= ent_dest_d;
        ent_data_q <= ent_data_d;   ent_target_q <= ent_target_d;
    end

    rob_query_port u_query1 (
        .query_tag (query_tag1), .busy (busy_q), .ready (ready_q), .data (ent_data_q),
        .cdb_valid (cdb_valid), .cdb_tag (cdb_tag), .cdb_data (cdb_data),
        .query_ready (query_ready1), .query_data (query_data1)
    );

    rob_query_port u_query2 (
        .query_tag (query_tag2), .busy (busy_q), .ready (ready_q), .data (ent_data_q),
        .cdb_valid (cdb_valid), .cdb_tag (cdb_tag), .cdb_data (cdb_data),
        .query_ready (query_ready2), .query_data (query_data2)
    );

    assign rob_full         = full_s;
    assign rob_next_tag     = idx_to_tag(tail_q);
    assign rob_valid        = rob_valid_q;
    assign dest             = dest_q;
    assign dest_depend      = dest_depend_q;
    assign rob_data         = rob_data_q;
    assign wrong_commit     = wrong_commit_q;
    assign flush_pc         = flush_pc_q;
    assign store_commit     = store_commit_q;
    assign store_commit_tag = store_tag_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed self-checking bench for rob_commit_unit; outputs sampled 1ns after posedge.
module tb_rob_commit_unit;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        dispatch_valid, dispatch_is_branch, dispatch_pred_taken;
    logic        dispatch_is_store, dispatch_ready;
    logic [4:0]  dispatch_dest;
    logic [31:0] dispatch_data;
    logic        rob_full;
    logic [4:0]  rob_next_tag;
    logic        cdb_valid, cdb_taken;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data, cdb_target;
    logic [4:0]  query_tag1, query_tag2;
    logic        query_ready1, query_ready2;
    logic [31:0] query_data1, query_data2;
    logic        rob_valid, wrong_commit, store_commit;
    logic [4:0]  dest, dest_depend, store_commit_tag;
    logic [31:0] rob_data, flush_pc;

    int n_checks = 0;
    int n_fail   = 0;

    rob_commit_unit dut (
        .clk (clk), .rst (rst), .rdy (rdy),
        .dispatch_valid (dispatch_valid), .dispatch_dest (dispatch_dest),
        .dispatch_is_branch (dispatch_is_branch), .dispatch_pred_taken (dispatch_pred_taken),
        .dispatch_is_store (dispatch_is_store), .dispatch_ready (dispatch_ready),
        .dispatch_data (dispatch_data), .rob_full (rob_full), .rob_next_tag (rob_next_tag),
        .cdb_valid (cdb_valid), .cdb_tag (cdb_tag), .cdb_data (cdb_data),
        .cdb_taken (cdb_taken), .cdb_target (cdb_target),
        .query_tag1 (query_tag1), .query_tag2 (query_tag2),
        .query_ready1 (query_ready1), .query_ready2 (query_ready2),
        .query_data1 (query_data1), .query_data2 (query_data2),
        .rob_valid (rob_valid), .dest (dest), .dest_depend (dest_depend),
        .rob_data (rob_data), .wrong_commit (wrong_commit), .flush_pc (flush_pc),
        .store_commit (store_commit), .store_commit_tag (store_commit_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_valid = 1'b0; dispatch_dest = 5'd0; dispatch_is_branch = 1'b0;
        dispatch_pred_taken = 1'b0; dispatch_is_store = 1'b0; dispatch_ready = 1'b0;
        dispatch_data = 32'd0; cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_data = 32'd0;
        cdb_taken = 1'b0; cdb_target = 32'd0; query_tag1 = 5'd0; query_tag2 = 5'd0;
    endtask

    task automatic set_dispatch(input logic [4:0] d, input logic br, input logic pt,
                                input logic st, input logic rd, input logic [31:0] data);
        dispatch_valid = 1'b1; dispatch_dest = d; dispatch_is_branch = br;
        dispatch_pred_taken = pt; dispatch_is_store = st; dispatch_ready = rd;
        dispatch_data = data;
    endtask

    task automatic set_cdb(input logic [4:0] t, input logic [31:0] d, input logic tk,
                           input logic [31:0] tgt);
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = d; cdb_taken = tk; cdb_target = tgt;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1; rdy = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check_eq("rst_next_tag", 32'(rob_next_tag), 32'd1);
        check_eq("rst_full", 32'(rob_full), 32'd0);
        check_eq("rst_valid", 32'(rob_valid), 32'd0);
        check_eq("rst_wrong", 32'(wrong_commit), 32'd0);
        check_eq("rst_flush_pc", flush_pc, 32'd0);

        // Basic dispatch, CDB write, commit.
        set_dispatch(5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        idle_inputs();
        check_eq("t1_next_tag", 32'(rob_next_tag), 32'd2);
        set_cdb(5'd1, 32'h55, 1'b0, 32'd0);
        step();
        idle_inputs();
        check_eq("t1_not_yet", 32'(rob_valid), 32'd0);
        step();
        check_eq("t1_valid", 32'(rob_valid), 32'd1);
        check_eq("t1_dest", 32'(dest), 32'd3);
        check_eq("t1_depend", 32'(dest_depend), 32'd1);
        check_eq("t1_data", rob_data, 32'h55);
        step();
        check_eq("t1_pulse", 32'(rob_valid), 32'd0);

        // Fill, refuse, commit-while-full refuse, wrap-around allocation.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_dispatch(5'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end
        check_eq("t2_full", 32'(rob_full), 32'd1);
        step();
        check_eq("t2_refused_tag", 32'(rob_next_tag), 32'd1);
        idle_inputs();
        set_cdb(5'd1, 32'hA1, 1'b0, 32'd0);
        step();
        idle_inputs();
        set_dispatch(5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
        step();
        check_eq("t2_commit", 32'(dest_depend), 32'd1);
        check_eq("t2_commit_data", rob_data, 32'hA1);
        check_eq("t2_simul_refused", 32'(rob_next_tag), 32'd1);
        check_eq("t2_not_full", 32'(rob_full), 32'd0);
        step();
        idle_inputs();
        check_eq("t2_wrap_tag", 32'(rob_next_tag), 32'd2);
        check_eq("t2_full_again", 32'(rob_full), 32'd1);

        // Branch misprediction and flush.
        do_reset();
        set_dispatch(5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
        step();
        set_dispatch(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        idle_inputs();
        check_eq("t3_c1_depend", 32'(dest_depend), 32'd1);
        check_eq("t3_c1_data", rob_data, 32'h11);
        set_cdb(5'd2, 32'd0, 1'b1, 32'h1000);
        step();
        idle_inputs();
        check_eq("t3_wait", 32'(rob_valid), 32'd0);
        step();
        check_eq("t3_br_valid", 32'(rob_valid), 32'd1);
        check_eq("t3_br_depend", 32'(dest_depend), 32'd2);
        check_eq("t3_no_wrong_yet", 32'(wrong_commit), 32'd0);
        check_eq("t3_full_in_flush", 32'(rob_full), 32'd1);
        set_dispatch(5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44);
        step();
        idle_inputs();
        check_eq("t3_wrong", 32'(wrong_commit), 32'd1);
        check_eq("t3_flush_pc", flush_pc, 32'h1000);
        check_eq("t3_valid_off", 32'(rob_valid), 32'd0);
        check_eq("t3_next_tag", 32'(rob_next_tag), 32'd1);
        step();
        check_eq("t3_wrong_pulse", 32'(wrong_commit), 32'd0);
        check_eq("t3_next_tag2", 32'(rob_next_tag), 32'd1);
        check_eq("t3_full_clear", 32'(rob_full), 32'd0);
        check_eq("t3_no_commit", 32'(rob_valid), 32'd0);

        // Query with same-cycle CDB bypass.
        for (int i = 0; i < 4; i++) begin
            set_dispatch(5'(i + 5), 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            step();
        end
        idle_inputs();
        query_tag1 = 5'd4; query_tag2 = 5'd0;
        set_cdb(5'd4, 32'hAB, 1'b0, 32'd0);
        #1;
        check_eq("t4_byp_ready", 32'(query_ready1), 32'd1);
        check_eq("t4_byp_data", query_data1, 32'hAB);
        check_eq("t4_tag0_ready", 32'(query_ready2), 32'd0);
        check_eq("t4_tag0_data", query_data2, 32'd0);
        step();
        cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_data = 32'd0;
        query_tag2 = 5'd3;
        #1;
        check_eq("t4_stored_ready", 32'(query_ready1), 32'd1);
        check_eq("t4_stored_data", query_data1, 32'hAB);
        check_eq("t4_pending", 32'(query_ready2), 32'd0);
        query_tag2 = 5'd9;
        #1;
        check_eq("t4_free_tag", 32'(query_ready2), 32'd0);

        // Store retirement.
        do_reset();
        set_dispatch(5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        set_dispatch(5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        step();
        idle_inputs();
        set_cdb(5'd1, 32'd5, 1'b0, 32'd0);
        step();
        idle_inputs();
        step();
        check_eq("t5_first_depend", 32'(dest_depend), 32'd1);
        check_eq("t5_no_store", 32'(store_commit), 32'd0);
        step();
        check_eq("t5_store", 32'(store_commit), 32'd1);
        check_eq("t5_store_tag", 32'(store_commit_tag), 32'd2);
        check_eq("t5_valid_dest0", 32'(rob_valid), 32'd1);
        check_eq("t5_dest0", 32'(dest), 32'd0);
        step();
        check_eq("t5_store_pulse", 32'(store_commit), 32'd0);
        check_eq("t5_valid_pulse", 32'(rob_valid), 32'd0);

        // rdy low freezes everything.
        do_reset();
        set_dispatch(5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 32'h66);
        step();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t6_frozen_valid", 32'(rob_valid), 32'd0);
        end
        check_eq("t6_frozen_tag", 32'(rob_next_tag), 32'd2);
        idle_inputs();
        rdy = 1'b1;
        step();
        check_eq("t6_valid", 32'(rob_valid), 32'd1);
        check_eq("t6_depend", 32'(dest_depend), 32'd1);
        check_eq("t6_data", rob_data, 32'h66);

        // Reset during flush wins.
        do_reset();
        set_dispatch(5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        step();
        idle_inputs();
        set_cdb(5'd1, 32'd0, 1'b0, 32'h2000);
        step();
        idle_inputs();
        step();
        check_eq("t7_br_valid", 32'(rob_valid), 32'd1);
        check_eq("t7_flushing", 32'(rob_full), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t7_wrong", 32'(wrong_commit), 32'd0);
        check_eq("t7_flush_pc", flush_pc, 32'd0);
        check_eq("t7_valid", 32'(rob_valid), 32'd0);
        check_eq("t7_depend", 32'(dest_depend), 32'd0);
        check_eq("t7_next_tag", 32'(rob_next_tag), 32'd1);
        check_eq("t7_full", 32'(rob_full), 32'd0);
        step();
        check_eq("t7_wrong_after", 32'(wrong_commit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer: allocates rename tags to dispatched instructions and collects results from the CDB.
- Retires at most one instruction per cycle, in program order, onto the register-file commit port (rob_valid/dest/dest_depend/rob_data/wrong_commit).
- Detects branch mispredictions at retirement and drives the global flush and the redirect PC.
- Sits between the dispatcher, the execution units (CDB) and the register file / load-store buffer.

Parameters:
- ROB_SIZE, 16, number of entries; must be ≤ 31 because tag 0 means "no dependency".
- TAG_W, 5, rename tag width; entry i carries tag i+1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; all state frozen when low
- dispatch_valid  in  1  allocate an entry this cycle
- dispatch_dest  in  5  architectural rd; 0 means no register write
- dispatch_is_branch  in  1  entry needs a misprediction check
- dispatch_pred_taken  in  1  predicted direction
- dispatch_is_store  in  1  store; retirement releases it to the LSB
- dispatch_ready  in  1  result already known at dispatch
- dispatch_data  in  32  result when dispatch_ready
- rob_full  out  1  allocation refused this cycle
- rob_next_tag  out  5  tag the next allocation receives
- cdb_valid  in  1  result broadcast
- cdb_tag  in  5  producing tag
- cdb_data  in  32  result value
- cdb_taken  in  1  actual branch direction
- cdb_target  in  32  correct next PC if mispredicted
- query_tag1, query_tag2  in  5  operand tags from the RF
- query_ready1, query_ready2  out  1  tagged value available (combinational)
- query_data1, query_data2  out  32  that value (combinational)
- rob_valid  out  1  commit to RF
- dest  out  5  rd of the committed entry
- dest_depend  out  5  tag of the committed entry
- rob_data  out  32  committed value
- wrong_commit  out  1  flush pulse
- flush_pc  out  32  redirect target, valid with wrong_commit
- store_commit  out  1  head store retired
- store_commit_tag  out  5  tag of that store

Behaviour:
- Storage:
  - Circular buffer with head, tail and a count of width clog2(ROB_SIZE)+1.
  - Per entry: busy, ready, dest, data, is_branch, pred_taken, taken, target, is_store.
- Reset (rst=1 at posedge):
  - head=tail=count=0; all busy=0; state=RUN.
  - All outputs 0, except rob_next_tag=1 and rob_full=0.
- rob_full = (count==ROB_SIZE) || state==FLUSH. rob_next_tag = tail+1.
- Dispatch: accepted when dispatch_valid && !rob_full. The entry at tail is written, ready=dispatch_ready, tail wraps ROB_SIZE-1 -> 0. Refused dispatch changes no state.
- CDB: when cdb_valid, the entry with tag cdb_tag takes ready=1, data, taken, target. A CDB write to a non-busy tag is ignored.
- Query, per port:
  - Tag 0 or non-busy -> ready=0, data=0.
  - Otherwise ready=entry.ready, data=entry.data.
  - Same-cycle CDB match bypasses: ready=1, data=cdb_data.
- Commit (state RUN, head busy && ready, rdy=1):
  - Registered outputs for exactly one cycle: rob_valid=1, dest, dest_depend=head+1, rob_data.
  - Store at head: store_commit=1, store_commit_tag=head+1.
  - Entry freed, head advances with wrap. rob_valid is pulsed even when dest=0.
- Misprediction: committing branch with taken != pred_taken.
  - Commit proceeds as above in cycle N; state -> FLUSH.
  - Cycle N+1: wrong_commit=1, flush_pc=target; all busy cleared; head=tail=count=0; state -> RUN.
  - No commit and no dispatch during FLUSH. CDB writes during FLUSH are ignored.
- Simultaneous events:
  - Dispatch and commit in the same cycle: count unchanged.
  - Dispatch into a full buffer whose head commits that cycle is still refused (rob_full is based on registered count).
  - CDB write to the head entry makes it commit-eligible the next cycle, not the same one.
- rdy=0: no state change. Pulse outputs deassert.
- Reset mid-flush: reset wins; wrong_commit=0.

Decomposition:
- Shared package / const_def: ROB_SIZE, TAG_W, the TAG_NONE=0 constant, and the state encoding RUN/FLUSH.
- One natural sub-module, rob_query_port: the combinational tag lookup with CDB bypass, instantiated twice.

Test Plan:
- Reset, then dispatch dest=3, dispatch_ready=0 -> rob_next_tag 1->2. CDB tag1 data=0x55 -> next cycle rob_valid=1, dest=3, dest_depend=1, rob_data=0x55.
- Dispatch 16 entries -> rob_full=1; 17th dispatch refused, tail unchanged. Commit one -> rob_full=0; the following dispatch gets tag 1 (wrap-around).
- Branch tag2, pred_taken=0; CDB taken=1, target=0x1000 -> cycle N: rob_valid, dest_depend=2. N+1: wrong_commit=1, flush_pc=0x1000. N+2: count=0, rob_next_tag=1.
- query_tag1=4 with CDB tag4 data=0xAB in the same cycle -> query_ready1=1, query_data1=0xAB. query_tag2=0 -> query_ready2=0.
- Store at head, ready -> store_commit=1, store_commit_tag = its tag, for one cycle only.
- rdy=0 for 3 cycles with the head ready -> no rob_valid. rdy=1 -> commit in the next cycle. rst asserted during FLUSH -> wrong_commit stays 0, all outputs at reset values.
